// File: rtl/uart_mutex_requester.sv
// Requester that claims a shared UART mutex with a prioritized start word.
// After the grant it streams data words separated by idle gaps and ends with a stop word.
//
// state | meaning
// IDLE  | no session, op_out idle
// REQ   | start word driven, waiting for mutex lock
// PROBE | first data word sent to test ownership
// PWAIT | waiting for owner echo matching NODE_ID
// DATA  | granted, one data word driven
// GAP   | idle words after a data word, echo captured
// STOP  | stop word driven, session closes
module uart_mutex_requester #(
  parameter logic [7:0] NODE_ID     = 8'h01,
  parameter int         GAP_CYCLES  = 2,
  parameter int         PROBE_WAIT  = 4,
  parameter int         REQ_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  input  logic [3:0]  req_prio,
  input  logic [7:0]  tx_byte,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [15:0] op_out,
  input  logic [15:0] mutex_node,
  input  logic        mutex_lock,
  input  logic        mutex_irq,
  input  logic        irq_ack,
  output logic        irq_pulse,
  output logic        irq_pending,
  output logic        busy,
  output logic        granted,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int TW  = $clog2(REQ_TIMEOUT + 1);
  localparam int PWW = $clog2(PROBE_WAIT + 1);
  localparam int GW  = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(REQ_TIMEOUT - 1);
  localparam logic [PWW-1:0] PW_LAST  = PWW'(PROBE_WAIT - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, PROBE, PWAIT, DATA, GAP, STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] op_q, op_d;
  logic        tx_ready_q, tx_ready_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        busy_q, busy_d;
  logic        granted_q, granted_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [3:0]  prio_q, prio_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [PWW-1:0] pw_q, pw_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic        last_q, last_d;
  logic        cap_q, cap_d;
  logic        irq_q, irq_pulse_q, irq_pend_q;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    tmo_d      = tmo_q;
    pw_d       = pw_q;
    gap_d      = gap_q;
    last_d     = last_q;
    cap_d      = cap_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready_d = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      IDLE: begin
        if (req_valid && tx_valid) begin
          prio_d  = (req_prio == 4'd0) ? 4'd1 : req_prio;
          tmo_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (tmo_q < TMO_LAST) tmo_d = tmo_q + TW'(1);
        if (tmo_q == TMO_LAST) begin
          state_d    = IDLE;
          err_d      = 1'b1;
          err_code_d = 2'b01;
        end else if (mutex_lock) begin
          state_d = PROBE;
          last_d  = tx_last;
        end
      end
      PROBE: begin
        if (tmo_q < TMO_LAST) tmo_d = tmo_q + TW'(1);
        pw_d    = '0;
        state_d = PWAIT;
      end
      PWAIT: begin
        if (tmo_q < TMO_LAST) tmo_d = tmo_q + TW'(1);
        if (mutex_node[15:8] == NODE_ID) begin
          state_d    = last_q ? STOP : GAP;
          tx_ready_d = 1'b1;
          rx_valid_d = 1'b1;
          rx_data_d  = mutex_node[7:0];
          gap_d      = '0;
          cap_d      = 1'b0;
        end else if (pw_q == PW_LAST) begin
          state_d = REQ;
        end else begin
          pw_d = pw_q + PWW'(1);
        end
      end
      DATA: begin
        if (!mutex_lock) begin
          state_d    = IDLE;
          err_d      = 1'b1;
          err_code_d = 2'b10;
          cap_d      = 1'b0;
        end else begin
          state_d = GAP;
          gap_d   = '0;
          cap_d   = 1'b1;
        end
      end
      GAP: begin
        if (!mutex_lock) begin
          state_d    = IDLE;
          err_d      = 1'b1;
          err_code_d = 2'b10;
          cap_d      = 1'b0;
        end else begin
          if (cap_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = mutex_node[7:0];
            cap_d      = 1'b0;
          end
          // A byte whose handshake completes this cycle must not be resent.
          if (gap_q != GAP_LAST) begin
            gap_d = gap_q + GW'(1);
          end else if (last_q) begin
            state_d = STOP;
          end else if (tx_valid && !tx_ready_q) begin
            state_d    = DATA;
            last_d     = tx_last;
            tx_ready_d = 1'b1;
          end
        end
      end
      STOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      REQ:         op_d = {12'hFBF, ~prio_d};
      PROBE, DATA: op_d = {8'h01, tx_byte};
      STOP:        op_d = 16'hFB00;
      default:     op_d = 16'h0000;
    endcase

    busy_d    = (state_d != IDLE);
    granted_d = (state_d == GAP) || (state_d == DATA);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      op_q       <= '0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
      granted_q  <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      prio_q     <= 4'd1;
      tmo_q      <= '0;
      pw_q       <= '0;
      gap_q      <= '0;
      last_q     <= 1'b0;
      cap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
      granted_q  <= granted_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      prio_q     <= prio_d;
      tmo_q      <= tmo_d;
      pw_q       <= pw_d;
      gap_q      <= gap_d;
      last_q     <= last_d;
      cap_q      <= cap_d;
    end
  end

  // An edge and an ack in the same cycle keep the pending flag set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      irq_q       <= 1'b0;
      irq_pulse_q <= 1'b0;
      irq_pend_q  <= 1'b0;
    end else begin
      irq_q       <= mutex_irq;
      irq_pulse_q <= mutex_irq && !irq_q;
      if (mutex_irq && !irq_q) irq_pend_q <= 1'b1;
      else if (irq_ack)        irq_pend_q <= 1'b0;
    end
  end

  assign op_out      = op_q;
  assign tx_ready    = tx_ready_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign busy        = busy_q;
  assign granted     = granted_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign irq_pulse   = irq_pulse_q;
  assign irq_pending = irq_pend_q;

endmodule

// File: tb/tb_uart_mutex_requester.sv
// Directed bench for uart_mutex_requester with hand-computed expected words.
module tb_uart_mutex_requester;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_prio = 4'd0;
  logic [7:0]  tx_byte = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_last = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] op_out;
  logic [15:0] mutex_node = 16'h0000;
  logic        mutex_lock = 1'b0;
  logic        mutex_irq = 1'b0;
  logic        irq_ack = 1'b0;
  logic        irq_pulse;
  logic        irq_pending;
  logic        busy;
  logic        granted;
  logic        err;
  logic [1:0]  err_code;

  int tests = 0;
  int fails = 0;
  int n;

  always #5 CLK = ~CLK;

  uart_mutex_requester dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_prio(req_prio),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .op_out(op_out), .mutex_node(mutex_node), .mutex_lock(mutex_lock),
    .mutex_irq(mutex_irq), .irq_ack(irq_ack),
    .irq_pulse(irq_pulse), .irq_pending(irq_pending),
    .busy(busy), .granted(granted), .err(err), .err_code(err_code)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    // reset state
    #3;
    chk("rst_op", 32'(op_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_granted", 32'(granted), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_errcode", 32'(err_code), 32'h0);
    chk("rst_irqpend", 32'(irq_pending), 32'h0);
    chk("rst_rxdata", 32'(rx_data), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // single byte with tx_last, echo 0155
    mutex_lock = 1'b1; mutex_node = 16'h0155;
    req_prio = 4'd15; tx_byte = 8'h41; tx_last = 1'b1; tx_valid = 1'b1; req_valid = 1'b1;
    tick();
    chk("t1_start", 32'(op_out), 32'hFBF0);
    chk("t1_busy", 32'(busy), 32'h1);
    req_valid = 1'b0;
    tick();
    chk("t1_probe", 32'(op_out), 32'h0141);
    tick();
    chk("t1_pwait", 32'(op_out), 32'h0000);
    chk("t1_rdy0", 32'(tx_ready), 32'h0);
    tick();
    chk("t1_stop", 32'(op_out), 32'hFB00);
    chk("t1_rdy1", 32'(tx_ready), 32'h1);
    chk("t1_rxv", 32'(rx_valid), 32'h1);
    chk("t1_rxd", 32'(rx_data), 32'h55);
    tx_valid = 1'b0;
    tick();
    chk("t1_idle_op", 32'(op_out), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_rdy_end", 32'(tx_ready), 32'h0);

    // req_valid without tx_valid is ignored
    req_valid = 1'b1;
    tick();
    chk("ign_busy", 32'(busy), 32'h0);
    chk("ign_op", 32'(op_out), 32'h0);
    req_valid = 1'b0;

    // mutex locked to the other node: probe expires
    mutex_node = 16'h0255;
    req_prio = 4'd3; tx_byte = 8'h77; tx_last = 1'b0; tx_valid = 1'b1; req_valid = 1'b1;
    tick();
    chk("t2_start", 32'(op_out), 32'hFBFC);
    req_valid = 1'b0;
    tick();
    chk("t2_probe", 32'(op_out), 32'h0177);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_pwait_op", 32'(op_out), 32'h0);
      chk("t2_pwait_rdy", 32'(tx_ready), 32'h0);
    end
    tick();
    chk("t2_retry", 32'(op_out), 32'hFBFC);
    chk("t2_rdy", 32'(tx_ready), 32'h0);
    tick();
    chk("t2_reprobe", 32'(op_out), 32'h0177);
    RST_N = 1'b0;
    #1;
    chk("t2_rst_op", 32'(op_out), 32'h0);
    chk("t2_rst_busy", 32'(busy), 32'h0);
    tx_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;

    // request timeout with mutex never locking
    mutex_lock = 1'b0;
    req_prio = 4'd3; tx_valid = 1'b1; req_valid = 1'b1;
    tick();
    chk("t3_start", 32'(op_out), 32'hFBFC);
    req_valid = 1'b0;
    n = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (op_out == 16'hFBFC) n++;
      else break;
    end
    chk("t3_cycles", 32'(n), 32'd255);
    chk("t3_err", 32'(err), 32'h1);
    chk("t3_code", 32'(err_code), 32'h1);
    chk("t3_busy", 32'(busy), 32'h0);
    chk("t3_op", 32'(op_out), 32'h0);
    tx_valid = 1'b0;
    tick();
    chk("t3_err_pulse", 32'(err), 32'h0);
    chk("t3_code_hold", 32'(err_code), 32'h1);

    // three bytes, prio 0 treated as 1
    mutex_lock = 1'b1; mutex_node = 16'h0177;
    req_prio = 4'd0; tx_byte = 8'h10; tx_last = 1'b0; tx_valid = 1'b1; req_valid = 1'b1;
    tick();
    chk("t4_start", 32'(op_out), 32'hFBFE);
    req_valid = 1'b0;
    tick();
    chk("t4_probe", 32'(op_out), 32'h0110);
    tick();
    chk("t4_pwait", 32'(op_out), 32'h0);
    tick();
    chk("t4_g1_op", 32'(op_out), 32'h0);
    chk("t4_g1_rdy", 32'(tx_ready), 32'h1);
    chk("t4_g1_rxv", 32'(rx_valid), 32'h1);
    chk("t4_g1_rxd", 32'(rx_data), 32'h77);
    chk("t4_granted", 32'(granted), 32'h1);
    tx_byte = 8'h20;
    tick();
    chk("t4_g2_op", 32'(op_out), 32'h0);
    chk("t4_g2_rxv", 32'(rx_valid), 32'h0);
    tick();
    chk("t4_d2_op", 32'(op_out), 32'h0120);
    chk("t4_d2_rdy", 32'(tx_ready), 32'h1);
    tx_byte = 8'h30; tx_last = 1'b1; mutex_node = 16'h0188;
    tick();
    chk("t4_d2g1_op", 32'(op_out), 32'h0);
    chk("t4_d2g1_rdy", 32'(tx_ready), 32'h0);
    tick();
    chk("t4_d2g2_op", 32'(op_out), 32'h0);
    chk("t4_d2g2_rxv", 32'(rx_valid), 32'h1);
    chk("t4_d2g2_rxd", 32'(rx_data), 32'h88);
    tick();
    chk("t4_d3_op", 32'(op_out), 32'h0130);
    chk("t4_d3_rdy", 32'(tx_ready), 32'h1);
    tx_valid = 1'b0; tx_last = 1'b0; mutex_node = 16'h0199;
    tick();
    chk("t4_d3g1_op", 32'(op_out), 32'h0);
    chk("t4_d3g1_granted", 32'(granted), 32'h1);
    tick();
    chk("t4_d3g2_op", 32'(op_out), 32'h0);
    chk("t4_d3g2_rxv", 32'(rx_valid), 32'h1);
    chk("t4_d3g2_rxd", 32'(rx_data), 32'h99);
    tick();
    chk("t4_stop", 32'(op_out), 32'hFB00);
    chk("t4_stop_granted", 32'(granted), 32'h0);
    tick();
    chk("t4_idle_op", 32'(op_out), 32'h0);
    chk("t4_idle_busy", 32'(busy), 32'h0);

    // lost grant during GAP
    mutex_node = 16'h0155;
    req_prio = 4'd2; tx_byte = 8'h5A; tx_last = 1'b0; tx_valid = 1'b1; req_valid = 1'b1;
    tick();
    chk("t5_start", 32'(op_out), 32'hFBFD);
    req_valid = 1'b0;
    tick();
    chk("t5_probe", 32'(op_out), 32'h015A);
    tick();
    tick();
    chk("t5_granted", 32'(granted), 32'h1);
    mutex_lock = 1'b0;
    tick();
    chk("t5_err", 32'(err), 32'h1);
    chk("t5_code", 32'(err_code), 32'h2);
    chk("t5_op", 32'(op_out), 32'h0);
    chk("t5_granted0", 32'(granted), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    tx_valid = 1'b0;
    tick();
    chk("t5_err_pulse", 32'(err), 32'h0);
    chk("t5_code_hold", 32'(err_code), 32'h2);
    chk("t5_no_stop", 32'(op_out), 32'h0);

    // reset during DATA
    mutex_lock = 1'b1;
    req_prio = 4'd15; tx_byte = 8'h33; tx_valid = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    tx_byte = 8'h44;
    tick();
    tick();
    chk("t6_data", 32'(op_out), 32'h0144);
    RST_N = 1'b0;
    #1;
    chk("t6_rst_op", 32'(op_out), 32'h0);
    chk("t6_rst_rdy", 32'(tx_ready), 32'h0);
    chk("t6_rst_granted", 32'(granted), 32'h0);
    chk("t6_rst_code", 32'(err_code), 32'h0);
    tx_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    chk("t6_after_op", 32'(op_out), 32'h0);
    chk("t6_after_busy", 32'(busy), 32'h0);

    // IRQ edge, ack, and simultaneous edge+ack
    mutex_irq = 1'b1;
    tick();
    chk("t7_pulse", 32'(irq_pulse), 32'h1);
    chk("t7_pend", 32'(irq_pending), 32'h1);
    tick();
    chk("t7_pulse_end", 32'(irq_pulse), 32'h0);
    chk("t7_pend_hold", 32'(irq_pending), 32'h1);
    irq_ack = 1'b1;
    tick();
    chk("t7_ack", 32'(irq_pending), 32'h0);
    irq_ack = 1'b0; mutex_irq = 1'b0;
    tick();
    mutex_irq = 1'b1; irq_ack = 1'b1;
    tick();
    chk("t7_both_pulse", 32'(irq_pulse), 32'h1);
    chk("t7_both_pend", 32'(irq_pending), 32'h1);
    irq_ack = 1'b0;
    tick();
    chk("t7_both_hold", 32'(irq_pending), 32'h1);
    chk("t7_no_repulse", 32'(irq_pulse), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
